moldudp64_sess_tracker: RTL

Multi-session sequence tracker placed after the MoldUDP64 header parser. It takes one parsed packet header per cycle and keeps the next-expected sequence number for up to SESS_N concurrent sessions. For each header it reports duplicate messages to drop, sequence gaps, and end-of-session events. It also flags sessions whose heartbeat has stopped. It replaces single-session MISS_DET/HEARTBEAT tracking with a parametrised session table.

---
 rtl/moldudp64_sess_tracker.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/moldudp64_sess_tracker.sv
// rtl/moldudp64_sess_tracker.sv - multi-session MoldUDP64 sequence tracker
//
// Purpose: keeps the next-expected sequence number for up to SESS_N sessions
// and classifies each parsed header as in-order, gap, duplicate, end of
// session or rejected. Also watches per-slot heartbeat idle time.
//
// Ports:
//   clk, reset (async, active-high)
//   hdr_v_i / hdr_sid_i / hdr_seq_num_i / hdr_msg_cnt_i : one parsed header per cycle
//   pkt_v_o, pkt_rej_o, pkt_slot_o, pkt_drop_cnt_o     : per-packet result (1 cycle later)
//   miss_v_o, miss_sid_o, miss_seq_num_start_o,
//   miss_seq_num_cnt_o                                   : gap report
//   eos_v_o                                              : session ended, slot freed
//   flatlined_o                                          : per-slot heartbeat lost (level)
module moldudp64_sess_tracker #(
    parameter int              SID_W       = 80,
    parameter int              SEQ_NUM_W   = 64,
    parameter int              ML_W        = 16,
    parameter int              SESS_N      = 4,
    parameter int              HB_TIMEOUT  = 1000,
    parameter logic [ML_W-1:0] EOS_MSG_CNT = 16'hFFFF,
    parameter int              SLOT_W      = (SESS_N > 1) ? $clog2(SESS_N) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 hdr_v_i,
    input  logic [SID_W-1:0]     hdr_sid_i,
    input  logic [SEQ_NUM_W-1:0] hdr_seq_num_i,
    input  logic [ML_W-1:0]      hdr_msg_cnt_i,
    output logic                 pkt_v_o,
    output logic                 pkt_rej_o,
    output logic [SLOT_W-1:0]    pkt_slot_o,
    output logic [ML_W-1:0]      pkt_drop_cnt_o,
    output logic                 miss_v_o,
    output logic [SID_W-1:0]     miss_sid_o,
    output logic [SEQ_NUM_W-1:0] miss_seq_num_start_o,
    output logic [SEQ_NUM_W-1:0] miss_seq_num_cnt_o,
    output logic                 eos_v_o,
    output logic [SESS_N-1:0]    flatlined_o
);

    localparam int                  HB_CNT_W = $clog2(HB_TIMEOUT + 1);
    localparam logic [HB_CNT_W-1:0] HB_MAX   = HB_CNT_W'(HB_TIMEOUT);

    // Session table
    logic [SESS_N-1:0]    valid_q, valid_d;
    logic [SID_W-1:0]     sid_q   [SESS_N];
    logic [SID_W-1:0]     sid_d   [SESS_N];
    logic [SEQ_NUM_W-1:0] exp_q   [SESS_N];
    logic [SEQ_NUM_W-1:0] exp_d   [SESS_N];
    logic [HB_CNT_W-1:0]  timer_q [SESS_N];
    logic [HB_CNT_W-1:0]  timer_d [SESS_N];

    // Registered per-packet results
    logic                 pkt_v_q, pkt_v_d;
    logic                 pkt_rej_q, pkt_rej_d;
    logic [SLOT_W-1:0]    pkt_slot_q, pkt_slot_d;
    logic [ML_W-1:0]      pkt_drop_q, pkt_drop_d;
    logic                 miss_v_q, miss_v_d;
    logic [SID_W-1:0]     miss_sid_q, miss_sid_d;
    logic [SEQ_NUM_W-1:0] miss_start_q, miss_start_d;
    logic [SEQ_NUM_W-1:0] miss_cnt_q, miss_cnt_d;
    logic                 eos_v_q, eos_v_d;

    // Parallel lookup of the header sid and lowest free slot
    logic                 hit;
    logic [SLOT_W-1:0]    hit_idx;
    logic [SEQ_NUM_W-1:0] hit_exp;
    logic                 free;
    logic [SLOT_W-1:0]    free_idx;

    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_exp  = '0;
        free     = 1'b0;
        free_idx = '0;
        for (int i = 0; i < SESS_N; i++) begin
            if (valid_q[i] && sid_q[i] == hdr_sid_i) begin
                hit     = 1'b1;
                hit_idx = SLOT_W'(i);
                hit_exp = exp_q[i];
            end
        end
        // Descending scan so the last assignment is the lowest free index
        for (int i = SESS_N - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free     = 1'b1;
                free_idx = SLOT_W'(i);
            end
        end
    end

    // Header arithmetic against the matched slot's expected sequence number
    logic                 is_hb;
    logic                 is_eos;
    logic [SEQ_NUM_W-1:0] cnt_ext;
    logic [SEQ_NUM_W-1:0] seq_end;
    logic [SEQ_NUM_W-1:0] ahead;
    logic [SEQ_NUM_W-1:0] behind;
    logic                 gap;
    logic [ML_W-1:0]      dup_cnt;

    assign is_hb   = (hdr_msg_cnt_i == '0);
    assign is_eos  = (hdr_msg_cnt_i == EOS_MSG_CNT);
    assign cnt_ext = SEQ_NUM_W'(hdr_msg_cnt_i);
    assign seq_end = hdr_seq_num_i + cnt_ext;
    assign gap     = (hdr_seq_num_i > hit_exp);
    assign ahead   = hdr_seq_num_i - hit_exp;
    assign behind  = hit_exp - hdr_seq_num_i;
    // Full-width compare before narrowing so large overlaps saturate to msg_cnt
    assign dup_cnt = (behind > cnt_ext) ? hdr_msg_cnt_i : behind[ML_W-1:0];

    always_comb begin
        valid_d = valid_q;
        sid_d   = sid_q;
        exp_d   = exp_q;
        for (int i = 0; i < SESS_N; i++) begin
            timer_d[i] = (valid_q[i] && timer_q[i] != HB_MAX) ?
                         timer_q[i] + HB_CNT_W'(1) : timer_q[i];
        end

        pkt_v_d      = 1'b0;
        pkt_rej_d    = 1'b0;
        pkt_slot_d   = '0;
        pkt_drop_d   = '0;
        miss_v_d     = 1'b0;
        miss_sid_d   = '0;
        miss_start_d = '0;
        miss_cnt_d   = '0;
        eos_v_d      = 1'b0;

        if (hdr_v_i) begin
            pkt_v_d = 1'b1;
            if (hit) begin
                pkt_slot_d   = hit_idx;
                miss_v_d     = gap;
                miss_sid_d   = hdr_sid_i;
                miss_start_d = hit_exp;
                miss_cnt_d   = ahead;
                eos_v_d      = is_eos;
                if (!is_hb && !is_eos) begin
                    pkt_drop_d = gap ? '0 : dup_cnt;
                end
                for (int i = 0; i < SESS_N; i++) begin
                    if (SLOT_W'(i) == hit_idx) begin
                        // Any hit clears the idle timer, winning over saturation
                        timer_d[i] = '0;
                        if (is_eos) begin
                            valid_d[i] = 1'b0;
                        end else if (is_hb) begin
                            if (gap) begin
                                exp_d[i] = hdr_seq_num_i;
                            end
                        end else begin
                            exp_d[i] = (seq_end > hit_exp) ? seq_end : hit_exp;
                        end
                    end
                end
            end else if (is_hb || is_eos) begin
                // Heartbeat/EOS for an unknown session never allocates
                pkt_rej_d = 1'b1;
            end else if (free) begin
                pkt_slot_d = free_idx;
                for (int i = 0; i < SESS_N; i++) begin
                    if (SLOT_W'(i) == free_idx) begin
                        valid_d[i] = 1'b1;
                        sid_d[i]   = hdr_sid_i;
                        exp_d[i]   = seq_end;
                        timer_d[i] = '0;
                    end
                end
            end else begin
                pkt_rej_d  = 1'b1;
                pkt_drop_d = hdr_msg_cnt_i;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < SESS_N; i++) begin
                sid_q[i]   <= '0;
                exp_q[i]   <= '0;
                timer_q[i] <= '0;
            end
            pkt_v_q      <= 1'b0;
            pkt_rej_q    <= 1'b0;
            pkt_slot_q   <= '0;
            pkt_drop_q   <= '0;
            miss_v_q     <= 1'b0;
            miss_sid_q   <= '0;
            miss_start_q <= '0;
            miss_cnt_q   <= '0;
            eos_v_q      <= 1'b0;
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < SESS_N; i++) begin
                sid_q[i]   <= sid_d[i];
                exp_q[i]   <= exp_d[i];
                timer_q[i] <= timer_d[i];
            end
            pkt_v_q      <= pkt_v_d;
            pkt_rej_q    <= pkt_rej_d;
            pkt_slot_q   <= pkt_slot_d;
            pkt_drop_q   <= pkt_drop_d;
            miss_v_q     <= miss_v_d;
            miss_sid_q   <= miss_sid_d;
            miss_start_q <= miss_start_d;
            miss_cnt_q   <= miss_cnt_d;
            eos_v_q      <= eos_v_d;
        end
    end

    always_comb begin
        flatlined_o = '0;
        for (int i = 0; i < SESS_N; i++) begin
            flatlined_o[i] = valid_q[i] && (timer_q[i] == HB_MAX);
        end
    end

    assign pkt_v_o              = pkt_v_q;
    assign pkt_rej_o            = pkt_rej_q;
    assign pkt_slot_o           = pkt_slot_q;
    assign pkt_drop_cnt_o       = pkt_drop_q;
    assign miss_v_o             = miss_v_q;
    assign miss_sid_o           = miss_sid_q;
    assign miss_seq_num_start_o = miss_start_q;
    assign miss_seq_num_cnt_o   = miss_cnt_q;
    assign eos_v_o              = eos_v_q;

endmodule
